// File: rtl/psum_acc_pkg.sv
// Shared geometry, FSM encoding and per-column arithmetic helpers for the
// post-array partial-sum accumulation stage.
package psum_acc_pkg;

    localparam int COL      = 8;
    localparam int PSUM_BW  = 16;
    localparam int A_DIM    = 6;
    localparam int O_DIM    = 4;
    localparam int K_DIM    = 3;
    localparam int LEN_NIJ  = A_DIM * A_DIM;
    localparam int LEN_KIJ  = K_DIM * K_DIM;
    localparam int LEN_ONIJ = O_DIM * O_DIM;
    localparam int ADDR_W   = 11;
    localparam int O_W      = 4;
    localparam int K_W      = 4;
    localparam int WORD_W   = COL * PSUM_BW;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_DRAIN = 2'd2,
        ST_HOLD  = 2'd3
    } state_e;

    // o_dim is a power of two, so onij row/col are plain bit fields of o.
    function automatic logic [ADDR_W-1:0] pmem_addr_of(
        input logic [O_W-1:0] o,
        input logic [K_W-1:0] k,
        input logic [1:0]     kr,
        input logic [1:0]     kc
    );
        logic [ADDR_W-1:0] base;
        logic [ADDR_W-1:0] row;
        logic [ADDR_W-1:0] colx;
        base = ADDR_W'(k) * ADDR_W'(LEN_NIJ);
        row  = ADDR_W'(o[3:2]) + ADDR_W'(kr);
        colx = ADDR_W'(o[1:0]) + ADDR_W'(kc);
        return base + row * ADDR_W'(A_DIM) + colx;
    endfunction

    function automatic logic [WORD_W-1:0] col_add(
        input logic [WORD_W-1:0] a,
        input logic [WORD_W-1:0] b
    );
        logic [WORD_W-1:0] r;
        r = '0;
        for (int c = 0; c < COL; c++) begin
            r[c*PSUM_BW +: PSUM_BW] = a[c*PSUM_BW +: PSUM_BW] + b[c*PSUM_BW +: PSUM_BW];
        end
        return r;
    endfunction

    function automatic logic [WORD_W-1:0] relu_word(
        input logic [WORD_W-1:0] w,
        input logic              en
    );
        logic [WORD_W-1:0] r;
        r = w;
        for (int c = 0; c < COL; c++) begin
            if (en && w[c*PSUM_BW + PSUM_BW - 1]) begin
                r[c*PSUM_BW +: PSUM_BW] = {PSUM_BW{1'b0}};
            end else begin
                r[c*PSUM_BW +: PSUM_BW] = w[c*PSUM_BW +: PSUM_BW];
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/psum_acc_sfp_addr_gen.sv
// pmem read-address generator: walks kij 0..8 for the current onij and
// presents registered pmem_addr/pmem_cen.
module psum_addr_gen
    import psum_acc_pkg::*;
(
    input  logic              clk,
    input  logic              reset,
    input  logic              restart_i,
    input  logic              next_o_i,
    input  logic              stop_i,
    output logic [O_W-1:0]    o_o,
    output logic [K_W-1:0]    k_o,
    output logic              pmem_cen,
    output logic [ADDR_W-1:0] pmem_addr
);

    logic [O_W-1:0]    o_q, o_d;
    logic [K_W-1:0]    k_q, k_d;
    logic [1:0]        kr_q, kr_d;
    logic [1:0]        kc_q, kc_d;
    logic              cen_q, cen_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [1:0]        nkr_s, nkc_s;

    // Next counter/address values; kernel row/col tracked directly to avoid k/3.
    always_comb begin
        o_d    = o_q;
        k_d    = k_q;
        kr_d   = kr_q;
        kc_d   = kc_q;
        cen_d  = cen_q;
        addr_d = addr_q;
        if (kc_q == 2'(K_DIM - 1)) begin
            nkc_s = 2'd0;
            nkr_s = kr_q + 2'd1;
        end else begin
            nkc_s = kc_q + 2'd1;
            nkr_s = kr_q;
        end
        if (stop_i) begin
            o_d    = '0;
            k_d    = '0;
            kr_d   = 2'd0;
            kc_d   = 2'd0;
            cen_d  = 1'b1;
            addr_d = '0;
        end else if (restart_i) begin
            o_d    = '0;
            k_d    = '0;
            kr_d   = 2'd0;
            kc_d   = 2'd0;
            cen_d  = 1'b0;
            addr_d = pmem_addr_of(4'd0, 4'd0, 2'd0, 2'd0);
        end else if (next_o_i) begin
            o_d    = o_q + 4'd1;
            k_d    = '0;
            kr_d   = 2'd0;
            kc_d   = 2'd0;
            cen_d  = 1'b0;
            addr_d = pmem_addr_of(o_q + 4'd1, 4'd0, 2'd0, 2'd0);
        end else if (!cen_q) begin
            if (k_q == 4'(LEN_KIJ - 1)) begin
                cen_d = 1'b1;
            end else begin
                k_d    = k_q + 4'd1;
                kr_d   = nkr_s;
                kc_d   = nkc_s;
                addr_d = pmem_addr_of(o_q, k_q + 4'd1, nkr_s, nkc_s);
            end
        end else begin
            cen_d = 1'b1;
        end
    end

    // Counter and pmem interface registers.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            o_q    <= '0;
            k_q    <= '0;
            kr_q   <= 2'd0;
            kc_q   <= 2'd0;
            cen_q  <= 1'b1;
            addr_q <= '0;
        end else begin
            o_q    <= o_d;
            k_q    <= k_d;
            kr_q   <= kr_d;
            kc_q   <= kc_d;
            cen_q  <= cen_d;
            addr_q <= addr_d;
        end
    end

    assign o_o       = o_q;
    assign k_o       = k_q;
    assign pmem_cen  = cen_q;
    assign pmem_addr = addr_q;

endmodule

// File: rtl/psum_acc_sfp.sv
// Accumulates the nine per-kij partial sums of each output pixel from pmem,
// applies optional ReLU and streams one word per onij over valid/ready.
module psum_acc_sfp
    import psum_acc_pkg::*;
(
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic              relu_en,
    output logic              busy,
    output logic              pmem_cen,
    output logic              pmem_wen,
    output logic [ADDR_W-1:0] pmem_addr,
    input  logic [WORD_W-1:0] pmem_q,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [WORD_W-1:0] out_data,
    output logic [3:0]        out_idx,
    output logic              done
);

    state_e            state_q, state_d;
    logic              relu_q, relu_d;
    logic [WORD_W-1:0] acc_q, acc_d;
    logic              out_valid_q, out_valid_d;
    logic [WORD_W-1:0] out_data_q, out_data_d;
    logic [3:0]        out_idx_q, out_idx_d;
    logic              done_q, done_d;
    logic              busy_q, busy_d;
    logic              restart_s, next_o_s, stop_s;
    logic [O_W-1:0]    o_s;
    logic [K_W-1:0]    k_s;
    logic [WORD_W-1:0] sum_s;

    psum_addr_gen u_addr_gen (
        .clk       (clk),
        .reset     (reset),
        .restart_i (restart_s),
        .next_o_i  (next_o_s),
        .stop_i    (stop_s),
        .o_o       (o_s),
        .k_o       (k_s),
        .pmem_cen  (pmem_cen),
        .pmem_addr (pmem_addr)
    );

    // FSM next state, accumulator and output-register updates.
    always_comb begin
        state_d     = state_q;
        relu_d      = relu_q;
        acc_d       = acc_q;
        out_valid_d = out_valid_q;
        out_data_d  = out_data_q;
        out_idx_d   = out_idx_q;
        done_d      = 1'b0;
        busy_d      = busy_q;
        restart_s   = 1'b0;
        next_o_s    = 1'b0;
        stop_s      = 1'b0;
        sum_s       = col_add(acc_q, pmem_q);
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    restart_s = 1'b1;
                    relu_d    = relu_en;
                    busy_d    = 1'b1;
                    state_d   = ST_ISSUE;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_ISSUE: begin
                // pmem_q carries kij (k_s-1); kij0 loads instead of adding.
                if (k_s == 4'd1) begin
                    acc_d = pmem_q;
                end else if (k_s != 4'd0) begin
                    acc_d = sum_s;
                end else begin
                    acc_d = acc_q;
                end
                if (k_s == 4'(LEN_KIJ - 1)) begin
                    state_d = ST_DRAIN;
                end else begin
                    state_d = ST_ISSUE;
                end
            end
            ST_DRAIN: begin
                acc_d       = sum_s;
                out_data_d  = relu_word(sum_s, relu_q);
                out_idx_d   = o_s;
                out_valid_d = 1'b1;
                state_d     = ST_HOLD;
            end
            ST_HOLD: begin
                if (out_ready) begin
                    out_valid_d = 1'b0;
                    if (o_s == 4'(LEN_ONIJ - 1)) begin
                        stop_s  = 1'b1;
                        done_d  = 1'b1;
                        busy_d  = 1'b0;
                        state_d = ST_IDLE;
                    end else begin
                        next_o_s = 1'b1;
                        state_d  = ST_ISSUE;
                    end
                end else begin
                    state_d = ST_HOLD;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State and output registers.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= ST_IDLE;
            relu_q      <= 1'b0;
            acc_q       <= '0;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_idx_q   <= 4'd0;
            done_q      <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            relu_q      <= relu_d;
            acc_q       <= acc_d;
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            out_idx_q   <= out_idx_d;
            done_q      <= done_d;
            busy_q      <= busy_d;
        end
    end

    assign pmem_wen  = 1'b1;
    assign busy      = busy_q;
    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;
    assign out_idx   = out_idx_q;
    assign done      = done_q;

endmodule

// File: tb/tb_psum_acc_sfp.sv
// Bench for psum_acc_sfp: pmem model, high-level accumulation model checked on
// every output/issue cycle, plus hand-computed literal expectations.
module tb_psum_acc_sfp;

    logic         clk = 1'b0;
    logic         reset;
    logic         start;
    logic         relu_en;
    logic         busy;
    logic         pmem_cen;
    logic         pmem_wen;
    logic [10:0]  pmem_addr;
    logic [127:0] pmem_q = '0;
    logic         out_valid;
    logic         out_ready;
    logic [127:0] out_data;
    logic [3:0]   out_idx;
    logic         done;

    logic [127:0] mem [0:323];
    logic [127:0] word_log [0:15];
    int           addr_log [0:143];

    int total = 0;
    int bad = 0;
    int exp_idx = 0;
    int mon_o = 0;
    int mon_k = 0;
    int done_cnt = 0;
    bit relu_exp = 1'b0;
    bit stall_prev = 1'b0;
    bit ia_flag = 1'b0;
    logic [127:0] prev_data;
    logic [3:0]   prev_idx;

    psum_acc_sfp dut (
        .clk       (clk),
        .reset     (reset),
        .start     (start),
        .relu_en   (relu_en),
        .busy      (busy),
        .pmem_cen  (pmem_cen),
        .pmem_wen  (pmem_wen),
        .pmem_addr (pmem_addr),
        .pmem_q    (pmem_q),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_idx   (out_idx),
        .done      (done)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (!pmem_cen && pmem_addr < 11'd324) pmem_q <= mem[pmem_addr];
    end

    task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%h required=%h", nm, act, exp);
        end
    endtask

    function automatic int baddr(input int o, input int k);
        return k * 36 + (o / 4 + k / 3) * 6 + (o % 4 + k % 3);
    endfunction

    function automatic logic [127:0] model_word(input int o);
        logic [127:0] r;
        r = '0;
        for (int c = 0; c < 8; c++) begin
            int s;
            logic [15:0] v;
            logic [127:0] w;
            s = 0;
            for (int k = 0; k < 9; k++) begin
                w = mem[baddr(o, k)];
                s += int'($signed(w[c*16 +: 16]));
            end
            v = 16'(s);
            if (relu_exp && v[15]) v = 16'd0;
            r[c*16 +: 16] = v;
        end
        return r;
    endfunction

    task automatic fill(input int mode, input logic [15:0] v);
        for (int a = 0; a < 324; a++) begin
            for (int c = 0; c < 8; c++) begin
                if (mode == 0) mem[a][c*16 +: 16] = v;
                else mem[a][c*16 +: 16] = 16'(a * 37 + c * 1001 + 40000);
            end
        end
    endtask

    // Per-cycle compare against the model: addresses, output words, handshake, done.
    always @(negedge clk) begin
        if (!reset) begin
            stall_prev = 1'b0;
            ia_flag = 1'b0;
        end else begin
            if (ia_flag) begin
                chk("issue_after_accept", pmem_cen, 1'b0);
                ia_flag = 1'b0;
            end
            if (!pmem_cen) begin
                if (mon_o < 16) begin
                    chk("pmem_addr", pmem_addr, baddr(mon_o, mon_k));
                    addr_log[mon_o * 9 + mon_k] = int'(pmem_addr);
                end else begin
                    chk("extra_read", 1'b1, 1'b0);
                end
                mon_k++;
                if (mon_k == 9) begin
                    mon_k = 0;
                    mon_o++;
                end
            end
            if (out_valid) begin
                if (exp_idx < 16) begin
                    chk("out_idx", out_idx, exp_idx);
                    chk("out_data", out_data, model_word(exp_idx));
                end else begin
                    chk("extra_word", 1'b1, 1'b0);
                end
                if (!out_ready) begin
                    chk("stall_cen", pmem_cen, 1'b1);
                    if (stall_prev) begin
                        chk("stall_data", out_data, prev_data);
                        chk("stall_idx", out_idx, prev_idx);
                    end
                    stall_prev = 1'b1;
                    prev_data = out_data;
                    prev_idx = out_idx;
                end else begin
                    stall_prev = 1'b0;
                    if (exp_idx < 16) word_log[exp_idx] = out_data;
                    if (exp_idx < 15) ia_flag = 1'b1;
                    exp_idx++;
                end
            end else begin
                stall_prev = 1'b0;
            end
            if (done) begin
                done_cnt++;
                chk("done_after_last", exp_idx, 16);
                chk("busy_at_done", busy, 1'b0);
            end
        end
    end

    task automatic chk_reset_vals(input string p);
        chk({p, "_busy"}, busy, 1'b0);
        chk({p, "_cen"}, pmem_cen, 1'b1);
        chk({p, "_wen"}, pmem_wen, 1'b1);
        chk({p, "_addr"}, pmem_addr, 11'd0);
        chk({p, "_valid"}, out_valid, 1'b0);
        chk({p, "_data"}, out_data, 128'd0);
        chk({p, "_idx"}, out_idx, 4'd0);
        chk({p, "_done"}, done, 1'b0);
    endtask

    task automatic begin_pass(input bit relu);
        exp_idx = 0;
        mon_o = 0;
        mon_k = 0;
        done_cnt = 0;
        relu_exp = relu;
        out_ready = 1'b1;
        @(posedge clk); #1;
        start = 1'b1;
        relu_en = relu;
        @(posedge clk); #1;
        start = 1'b0;
        relu_en = ~relu;
        chk("busy_after_start", busy, 1'b1);
    endtask

    task automatic run_pass(input bit relu, input bit bp, output int first_n, output int done_n);
        int n;
        int stall;
        begin_pass(relu);
        n = 1;
        first_n = -1;
        done_n = -1;
        stall = 0;
        while (n < 600 && done_cnt == 0) begin
            @(posedge clk); #1;
            n++;
            start = 1'b0;
            if (out_valid && first_n < 0) first_n = n;
            if (done) done_n = n;
            if (bp && out_valid && out_idx == 4'd3 && stall < 5) begin
                out_ready = 1'b0;
                stall++;
                if (stall == 2) start = 1'b1;
            end else begin
                out_ready = 1'b1;
            end
        end
        start = 1'b0;
        out_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        chk("done_count", done_cnt, 1);
        chk("words_seen", exp_idx, 16);
        chk("idle_after_pass", busy, 1'b0);
    endtask

    task automatic run_reset();
        int n;
        begin_pass(1'b0);
        n = 0;
        while (n < 300 && !(mon_o == 7 && mon_k >= 2 && !pmem_cen)) begin
            @(posedge clk); #1;
            n++;
        end
        chk("reset_point_reached", (n < 300), 1'b1);
        #2;
        reset = 1'b0;
        #1;
        chk_reset_vals("midreset");
        repeat (3) @(posedge clk);
        #1;
        chk_reset_vals("held_reset");
        chk("no_done_after_reset", done_cnt, 0);
        #2;
        reset = 1'b1;
    endtask

    initial begin
        int f;
        int d;
        int nij0 [0:8];
        logic [127:0] w9;
        nij0 = '{0, 1, 2, 6, 7, 8, 12, 13, 14};
        reset = 1'b0;
        start = 1'b0;
        relu_en = 1'b0;
        out_ready = 1'b0;
        fill(0, 16'h0000);
        #13;
        chk_reset_vals("por");
        @(posedge clk); #2;
        reset = 1'b1;

        fill(0, 16'h0001);
        run_pass(1'b0, 1'b0, f, d);
        chk("first_valid_latency", f, 11);
        chk("done_latency", d, 177);
        w9 = {8{16'h0009}};
        chk("ones_word0", word_log[0], w9);
        chk("ones_word15", word_log[15], w9);
        for (int k = 0; k < 9; k++) chk("onij0_nij", addr_log[k] - k * 36, nij0[k]);
        chk("addr_o5_k4", addr_log[5 * 9 + 4], 158);
        chk("addr_o15_k8", addr_log[143], 323);

        fill(0, 16'hFFFD);
        run_pass(1'b1, 1'b0, f, d);
        chk("neg_relu_word0", word_log[0], 128'd0);
        run_pass(1'b0, 1'b0, f, d);
        chk("neg_word7", word_log[7], {8{16'hFFE5}});

        fill(0, 16'h7FFF);
        run_pass(1'b0, 1'b0, f, d);
        chk("wrap_word2", word_log[2], {8{16'h7FF7}});

        fill(1, 16'h0000);
        run_pass(1'b1, 1'b1, f, d);
        chk("bp_first_valid", f, 11);
        chk("bp_done_latency", d, 182);

        run_reset();
        run_pass(1'b0, 1'b0, f, d);
        chk("post_reset_latency", f, 11);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout actual=running required=finished");
        $fatal(1);
    end

endmodule
